pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage pipeline. It sequences the PC, IF/ID, ID/EX and EX/MEM pipeline registers by driving write-enable, hold, flush and bubble controls. It resolves load-use stalls, taken branch/jump redirects and multi-cycle EX operations (MUL/DIV), and generates EX-stage forwarding selects. FSM state and counters update on CLK rising edge; control outputs are a combinational decode of state and current inputs.

Parameters:
REDIRECT_BUBBLES, 1, number of cycles IF_ID_Flush stays asserted after a redirect; legal range 1..4.
MC_TIMEOUT, 64, maximum cycles spent in MC_WAIT before forced abort; must be at least 2.

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
Ra_ID  in  5  rs1 address of instruction in ID
Rb_ID  in  5  rs2 address of instruction in ID
UseRa_ID  in  1  ID instruction reads rs1
UseRb_ID  in  1  ID instruction reads rs2
Ra_EX  in  5  rs1 address in EX
Rb_EX  in  5  rs2 address in EX
Rd_EX  in  5  destination in EX
RegWr_EX  in  1  EX instruction writes a register
MemtoReg_EX  in  1  EX instruction is a load
Rd_MEM  in  5  destination in MEM
RegWr_MEM  in  1  MEM instruction writes a register
Rd_WB  in  5  destination in WB
RegWr_WB  in  1  WB instruction writes a register
Redirect_EX  in  1  taken branch or jump resolved in EX
MC_Start_EX  in  1  multi-cycle op present in EX
MC_Done  in  1  multi-cycle unit result valid
PC_Wr  out  1  PC update enable
PC_Sel  out  1  1 = load redirect target
IF_ID_Wr  out  1  IF/ID write enable
IF_ID_Flush  out  1  IF/ID clear to NOP
ID_EX_Hold  out  1  ID/EX freeze
ID_EX_Flush  out  1  ID/EX clear to bubble (all control 0)
EX_MEM_Bubble  out  1  EX/MEM loads bubble
ForwardA  out  2  busA source: 00 reg file, 10 MEM, 01 WB
ForwardB  out  2  busB source, same encoding
MC_Timeout  out  1  one-cycle pulse on MC abort
Stall_Cycles  out  32  perf counter (see feature)
Flush_Count  out  32  perf counter (see feature)

Behaviour:
- States RUN, REDIR, MC_WAIT. Reset: state RUN, redirect and timeout counters 0, MC_Timeout 0. Outputs during Reset: PC_Wr=1, IF_ID_Wr=1, all flush/hold/bubble/PC_Sel 0, Forward 00.
- RUN, defaults: PC_Wr=1, IF_ID_Wr=1, all other controls 0.
- Priority within RUN: Redirect_EX > MC_Start_EX > load-use.
- Redirect_EX: PC_Sel=1, IF_ID_Flush=1, ID_EX_Flush=1 in the same cycle. If REDIRECT_BUBBLES>1, go to REDIR; otherwise stay in RUN.
- REDIR: IF_ID_Flush=1, PC_Wr=1, PC_Sel=0. Stay for REDIRECT_BUBBLES-1 cycles, then go to RUN. A Redirect_EX while in REDIR is ignored, because EX holds only bubbles in that state.
- MC_Start_EX: enter MC_WAIT next cycle. The entry cycle already asserts PC_Wr=0, IF_ID_Wr=0, ID_EX_Hold=1, EX_MEM_Bubble=1.
- MC_WAIT: holds those four values while MC_Done=0; the timeout counter increments each cycle.
  - MC_Done=1: EX_MEM_Bubble=0, ID_EX_Hold=0, PC_Wr=1, IF_ID_Wr=1; next state RUN.
  - MC_Done arriving in the same cycle as MC_Start_EX (1-cycle op): no stall at all.
  - Counter reaches MC_TIMEOUT-1 without MC_Done: pulse MC_Timeout, release as if done with EX_MEM_Bubble=1, return to RUN.
- Load-use, checked only in RUN: condition is MemtoReg_EX & RegWr_EX & Rd_EX!=0 & ((UseRa_ID & Ra_ID==Rd_EX) | (UseRb_ID & Rb_ID==Rd_EX)). Response is PC_Wr=0, IF_ID_Wr=0, ID_EX_Flush=1 for exactly one cycle; no state change.
- Forwarding, always combinational:
  - ForwardA=10 if RegWr_MEM & Rd_MEM!=0 & Rd_MEM==Ra_EX.
  - Else ForwardA=01 if RegWr_WB & Rd_WB!=0 & Rd_WB==Ra_EX.
  - Else ForwardA=00.
  - ForwardB uses the same rules with Rb_EX. MEM beats WB.
- Reset asserted mid-MC_WAIT or mid-REDIR: next cycle is RUN with counters cleared; no MC_Timeout pulse.

Optional Feature:
HAZARD_PERF_EN
- Defined: Stall_Cycles increments on every cycle with PC_Wr=0. Flush_Count increments on every Redirect_EX accepted in RUN. Both are 32-bit, saturate at all-ones, and clear on Reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum (RUN=2'd0, REDIR=2'd1, MC_WAIT=2'd2);
  - forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - register-index width 5.
- Sub-module fwd_unit: purely combinational ForwardA/B logic, instantiated once.

Test Plan:
- Load x5 in EX (Rd_EX=5, MemtoReg_EX=1), ID uses Ra_ID=5 -> one cycle PC_Wr=0, IF_ID_Wr=0, ID_EX_Flush=1; same case with Rd_EX=0 -> no stall.
- Redirect_EX pulse with REDIRECT_BUBBLES=3 -> PC_Sel=1 for 1 cycle; IF_ID_Flush=1 for 3 cycles; ID_EX_Flush=1 for 1 cycle.
- MC_Start_EX, MC_Done 5 cycles later -> stall outputs held for 5 cycles, released on the 6th, EX_MEM_Bubble=0 in the Done cycle.
- MC_Start_EX, MC_Done never, MC_TIMEOUT=8 -> MC_Timeout pulses in the 8th cycle, state returns to RUN.
- Rd_MEM=Rd_WB=Ra_EX=7, both RegWr -> ForwardA=10; drop RegWr_MEM -> 01; Ra_EX=0 -> 00.
- Reset asserted in MC_WAIT cycle 3 -> next cycle RUN, PC_Wr=1, no MC_Timeout; with HAZARD_PERF_EN, Stall_Cycles reads 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, forward selects and register-index width for the hazard controller
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        REDIR   = 2'd1,
        MC_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // MEM result is younger than WB, so it wins; x0 is never forwarded
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rd_mem,
        input logic             wr_mem,
        input logic [REG_W-1:0] rd_wb,
        input logic             wr_wb
    );
        return (wr_mem && rd_mem != '0 && rd_mem == rs) ? FWD_MEM :
               (wr_wb  && rd_wb  != '0 && rd_wb  == rs) ? FWD_WB  : FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// fwd_unit: combinational EX-stage operand forwarding selects
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] Ra_EX,
    input  logic [REG_W-1:0] Rb_EX,
    input  logic [REG_W-1:0] Rd_MEM,
    input  logic             RegWr_MEM,
    input  logic [REG_W-1:0] Rd_WB,
    input  logic             RegWr_WB,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB
);

    assign ForwardA = fwd_sel(Ra_EX, Rd_MEM, RegWr_MEM, Rd_WB, RegWr_WB);
    assign ForwardB = fwd_sel(Rb_EX, Rd_MEM, RegWr_MEM, Rd_WB, RegWr_WB);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline stall/flush/forward controller; HAZARD_PERF_EN adds saturating perf counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int MC_TIMEOUT       = 64
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [REG_W-1:0] Ra_ID,
    input  logic [REG_W-1:0] Rb_ID,
    input  logic             UseRa_ID,
    input  logic             UseRb_ID,
    input  logic [REG_W-1:0] Ra_EX,
    input  logic [REG_W-1:0] Rb_EX,
    input  logic [REG_W-1:0] Rd_EX,
    input  logic             RegWr_EX,
    input  logic             MemtoReg_EX,
    input  logic [REG_W-1:0] Rd_MEM,
    input  logic             RegWr_MEM,
    input  logic [REG_W-1:0] Rd_WB,
    input  logic             RegWr_WB,
    input  logic             Redirect_EX,
    input  logic             MC_Start_EX,
    input  logic             MC_Done,
    output logic             PC_Wr,
    output logic             PC_Sel,
    output logic             IF_ID_Wr,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Hold,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Bubble,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             MC_Timeout,
    output logic [31:0]      Stall_Cycles,
    output logic [31:0]      Flush_Count
);

    localparam int              TW      = $clog2(MC_TIMEOUT);
    localparam logic [TW-1:0]   TO_LAST = TW'(MC_TIMEOUT - 1);
    localparam logic [1:0]      RD_LAST = 2'(REDIRECT_BUBBLES - 2);

    state_t         state, state_n;
    logic [1:0]     rd_cnt;
    logic [TW-1:0]  to_cnt;
    logic           load_use;

    assign load_use = MemtoReg_EX && RegWr_EX && Rd_EX != '0 &&
                      ((UseRa_ID && Ra_ID == Rd_EX) || (UseRb_ID && Rb_ID == Rd_EX));

    fwd_unit u_fwd (
        .Ra_EX     (Ra_EX),
        .Rb_EX     (Rb_EX),
        .Rd_MEM    (Rd_MEM),
        .RegWr_MEM (RegWr_MEM),
        .Rd_WB     (Rd_WB),
        .RegWr_WB  (RegWr_WB),
        .ForwardA  (ForwardA),
        .ForwardB  (ForwardB)
    );

    // state register plus redirect/timeout counters, each cleared whenever its state is left
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state  <= RUN;
            rd_cnt <= '0;
            to_cnt <= '0;
        end else begin
            state  <= state_n;
            rd_cnt <= (state == REDIR && state_n == REDIR) ? rd_cnt + 2'd1 : 2'd0;
            to_cnt <= (state == MC_WAIT && state_n == MC_WAIT) ? to_cnt + 1'b1 : '0;
        end
    end

    // next state and control decode; Reset forces the free-running defaults regardless of state
    always_comb begin
        state_n       = state;
        PC_Wr         = 1'b1;
        PC_Sel        = 1'b0;
        IF_ID_Wr      = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Hold    = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Bubble = 1'b0;
        MC_Timeout    = 1'b0;
        if (!Reset) begin
            case (state)
                RUN: begin
                    if (Redirect_EX) begin
                        PC_Sel      = 1'b1;
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                        state_n     = (REDIRECT_BUBBLES > 1) ? REDIR : RUN;
                    end else if (MC_Start_EX) begin
                        if (!MC_Done) begin
                            PC_Wr         = 1'b0;
                            IF_ID_Wr      = 1'b0;
                            ID_EX_Hold    = 1'b1;
                            EX_MEM_Bubble = 1'b1;
                            state_n       = MC_WAIT;
                        end
                    end else if (load_use) begin
                        PC_Wr       = 1'b0;
                        IF_ID_Wr    = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end
                end
                REDIR: begin
                    IF_ID_Flush = 1'b1;
                    state_n     = (rd_cnt == RD_LAST) ? RUN : REDIR;
                end
                MC_WAIT: begin
                    if (MC_Done) begin
                        state_n = RUN;
                    end else if (to_cnt == TO_LAST) begin
                        MC_Timeout    = 1'b1;
                        EX_MEM_Bubble = 1'b1;
                        state_n       = RUN;
                    end else begin
                        PC_Wr         = 1'b0;
                        IF_ID_Wr      = 1'b0;
                        ID_EX_Hold    = 1'b1;
                        EX_MEM_Bubble = 1'b1;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q, flush_q;
    logic        redir_acc;

    assign redir_acc = state == RUN && Redirect_EX;

    // saturating counts of PC-stalled cycles and accepted redirects
    always_ff @(posedge CLK) begin
        if (Reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!PC_Wr && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (redir_acc && flush_q != '1) flush_q <= flush_q + 32'd1;
        end
    end

    assign Stall_Cycles = stall_q;
    assign Flush_Count  = flush_q;
`else
    assign Stall_Cycles = '0;
    assign Flush_Count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector and sequence checks of the hazard controller (REDIRECT_BUBBLES=3, MC_TIMEOUT=8)
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       Reset;
    logic [4:0] Ra_ID, Rb_ID, Ra_EX, Rb_EX, Rd_EX, Rd_MEM, Rd_WB;
    logic       UseRa_ID, UseRb_ID, RegWr_EX, MemtoReg_EX, RegWr_MEM, RegWr_WB;
    logic       Redirect_EX, MC_Start_EX, MC_Done;
    logic       PC_Wr, PC_Sel, IF_ID_Wr, IF_ID_Flush, ID_EX_Hold, ID_EX_Flush, EX_MEM_Bubble, MC_Timeout;
    logic [1:0] ForwardA, ForwardB;
    logic [31:0] Stall_Cycles, Flush_Count;
    logic [7:0] ctl;

    int passed = 0;
    int total  = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.REDIRECT_BUBBLES(3), .MC_TIMEOUT(8)) dut (
        .CLK(CLK), .Reset(Reset),
        .Ra_ID(Ra_ID), .Rb_ID(Rb_ID), .UseRa_ID(UseRa_ID), .UseRb_ID(UseRb_ID),
        .Ra_EX(Ra_EX), .Rb_EX(Rb_EX), .Rd_EX(Rd_EX), .RegWr_EX(RegWr_EX), .MemtoReg_EX(MemtoReg_EX),
        .Rd_MEM(Rd_MEM), .RegWr_MEM(RegWr_MEM), .Rd_WB(Rd_WB), .RegWr_WB(RegWr_WB),
        .Redirect_EX(Redirect_EX), .MC_Start_EX(MC_Start_EX), .MC_Done(MC_Done),
        .PC_Wr(PC_Wr), .PC_Sel(PC_Sel), .IF_ID_Wr(IF_ID_Wr), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Hold(ID_EX_Hold), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Bubble(EX_MEM_Bubble),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .MC_Timeout(MC_Timeout),
        .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count)
    );

    // control bits: PC_Wr PC_Sel IF_ID_Wr IF_ID_Flush ID_EX_Hold ID_EX_Flush EX_MEM_Bubble MC_Timeout
    assign ctl = {PC_Wr, PC_Sel, IF_ID_Wr, IF_ID_Flush, ID_EX_Hold, ID_EX_Flush, EX_MEM_Bubble, MC_Timeout};

    localparam logic [7:0] C_RUN   = 8'hA0;
    localparam logic [7:0] C_REDIR = 8'hF4;
    localparam logic [7:0] C_RFLSH = 8'hB0;
    localparam logic [7:0] C_LDUSE = 8'h04;
    localparam logic [7:0] C_MCSTL = 8'h0A;
    localparam logic [7:0] C_MCTO  = 8'hA3;

    typedef struct {
        logic [4:0] ra_id, rb_id;
        logic       use_a, use_b;
        logic [4:0] rd_ex;
        logic       rw_ex, ld_ex;
        logic [4:0] ra_ex, rb_ex, rd_mem;
        logic       rw_mem;
        logic [4:0] rd_wb;
        logic       rw_wb;
        logic [7:0] ctl;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic idle_inputs();
        {Ra_ID, Rb_ID, Ra_EX, Rb_EX, Rd_EX, Rd_MEM, Rd_WB} = '0;
        {UseRa_ID, UseRb_ID, RegWr_EX, MemtoReg_EX, RegWr_MEM, RegWr_WB} = '0;
        {Redirect_EX, MC_Start_EX, MC_Done} = '0;
    endtask

    task automatic cyc(input string nm, input logic [7:0] exp);
        @(negedge CLK);
        chk(nm, 32'(ctl), 32'(exp));
        if (!exp[7]) exp_stall++;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_perf(input string nm);
        chk({nm, "_stall"}, Stall_Cycles, PERF ? 32'(exp_stall) : 32'd0);
        chk({nm, "_flush"}, Flush_Count,  PERF ? 32'(exp_flush) : 32'd0);
    endtask

    initial begin
        //              ra_id  rb_id  ua    ub    rd_ex  rw    ld    ra_ex  rb_ex   rd_mem rwm   rd_wb   rww   ctl      fa     fb
        vecs[0]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, C_LDUSE, 2'b00, 2'b00};
        vecs[1]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, C_RUN,   2'b00, 2'b00};
        vecs[2]  = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, C_LDUSE, 2'b00, 2'b00};
        vecs[3]  = '{5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, C_RUN,   2'b00, 2'b00};
        vecs[4]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, C_RUN,   2'b00, 2'b00};
        vecs[5]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 5'd0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, C_RUN,   2'b00, 2'b00};
        vecs[6]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, C_RUN,   2'b00, 2'b00};
        vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd3,  5'd7, 1'b1, 5'd7,  1'b1, C_RUN,   2'b10, 2'b00};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd3,  5'd7, 1'b0, 5'd7,  1'b1, C_RUN,   2'b01, 2'b00};
        vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0,  5'd0, 1'b1, 5'd0,  1'b1, C_RUN,   2'b00, 2'b00};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd9,  5'd9, 1'b1, 5'd9,  1'b1, C_RUN,   2'b10, 2'b10};
        vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd12, 5'd4, 1'b1, 5'd12, 1'b1, C_RUN,   2'b10, 2'b01};
        vecs[12] = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 5'd6, 5'd0,  5'd0, 1'b0, 5'd6,  1'b1, C_LDUSE, 2'b01, 2'b00};
        vecs[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd8, 5'd7,  5'd7, 1'b1, 5'd8,  1'b0, C_RUN,   2'b00, 2'b10};

        idle_inputs();
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Redirect_EX = 1'b1; MC_Start_EX = 1'b1;
        cyc("reset_ctl", C_RUN);
        chk("reset_fwd", 32'({ForwardA, ForwardB}), 32'd0);
        Reset = 1'b0;
        idle_inputs();
        chk_perf("after_reset");

        for (int i = 0; i < 14; i++) begin
            {Ra_ID, Rb_ID, UseRa_ID, UseRb_ID} = {vecs[i].ra_id, vecs[i].rb_id, vecs[i].use_a, vecs[i].use_b};
            {Rd_EX, RegWr_EX, MemtoReg_EX}     = {vecs[i].rd_ex, vecs[i].rw_ex, vecs[i].ld_ex};
            {Ra_EX, Rb_EX, Rd_MEM, RegWr_MEM}  = {vecs[i].ra_ex, vecs[i].rb_ex, vecs[i].rd_mem, vecs[i].rw_mem};
            {Rd_WB, RegWr_WB}                  = {vecs[i].rd_wb, vecs[i].rw_wb};
            @(negedge CLK);
            chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].ctl));
            chk($sformatf("vec%0d_fwd", i), 32'({ForwardA, ForwardB}), 32'({vecs[i].fa, vecs[i].fb}));
            if (!vecs[i].ctl[7]) exp_stall++;
            @(posedge CLK);
            #1;
        end
        idle_inputs();
        cyc("post_table", C_RUN);

        Redirect_EX = 1'b1;
        cyc("redir_accept", C_REDIR);
        exp_flush++;
        cyc("redir_ignored", C_RFLSH);
        Redirect_EX = 1'b0;
        cyc("redir_bubble3", C_RFLSH);
        cyc("redir_done", C_RUN);

        MC_Start_EX = 1'b1;
        cyc("mc_entry", C_MCSTL);
        for (int i = 1; i <= 4; i++) cyc($sformatf("mc_wait%0d", i), C_MCSTL);
        MC_Done = 1'b1;
        cyc("mc_done", C_RUN);
        MC_Start_EX = 1'b0; MC_Done = 1'b0;
        cyc("mc_after", C_RUN);

        MC_Start_EX = 1'b1; MC_Done = 1'b1;
        cyc("mc_1cyc", C_RUN);
        MC_Start_EX = 1'b0; MC_Done = 1'b0;
        cyc("mc_1cyc_after", C_RUN);

        MC_Start_EX = 1'b1;
        cyc("to_entry", C_MCSTL);
        for (int i = 1; i <= 7; i++) cyc($sformatf("to_wait%0d", i), C_MCSTL);
        cyc("to_pulse", C_MCTO);
        MC_Start_EX = 1'b0;
        cyc("to_after", C_RUN);
        chk_perf("mid");

        MC_Start_EX = 1'b1;
        cyc("rst_entry", C_MCSTL);
        cyc("rst_wait1", C_MCSTL);
        cyc("rst_wait2", C_MCSTL);
        Reset = 1'b1;
        cyc("rst_wait3", C_RUN);
        Reset = 1'b0; MC_Start_EX = 1'b0;
        exp_stall = 0; exp_flush = 0;
        cyc("rst_run", C_RUN);
        chk_perf("after_mid_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
